// File: rtl/csr_trap_ctrl_pkg.sv
// Shared encodings for the machine-mode trap sequencer: instruction patterns,
// CSR addresses, mcause codes, mstatus bit positions and FSM states.
package csr_trap_ctrl_pkg;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL     = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
  localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T_MEPC,
    ST_T_MSTATUS,
    ST_T_MCAUSE,
    ST_T_JUMP,
    ST_R_MSTATUS,
    ST_R_JUMP
  } trap_state_e;

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// Bundle of exe-stage inputs, CSR-file values, mem-stage CSR write request and
// the sequencer's CSR write / pipeline control outputs. The trap controller
// uses the master side; the surrounding pipeline uses the slave side.
interface csr_trap_ctrl_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
);

  logic [DATA_WIDTH-1:0]     inst_in;
  logic [ADDR_WIDTH-1:0]     inst_address_in;
  logic                      irq_in;
  logic [DATA_WIDTH-1:0]     csr_mstatus_in;
  logic [DATA_WIDTH-1:0]     csr_mtvec_in;
  logic [DATA_WIDTH-1:0]     csr_mepc_in;
  logic                      pipe_csr_we_in;
  logic [CSR_ADDR_WIDTH-1:0] pipe_csr_waddr_in;
  logic [DATA_WIDTH-1:0]     pipe_csr_wdata_in;
  logic                      csr_we_out;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_out;
  logic [DATA_WIDTH-1:0]     csr_wdata_out;
  logic                      hold_out;
  logic                      jump_enable_out;
  logic [ADDR_WIDTH-1:0]     jump_address_out;
  logic                      busy_out;

  modport master (
    input  inst_in, inst_address_in, irq_in,
    input  csr_mstatus_in, csr_mtvec_in, csr_mepc_in,
    input  pipe_csr_we_in, pipe_csr_waddr_in, pipe_csr_wdata_in,
    output csr_we_out, csr_waddr_out, csr_wdata_out,
    output hold_out, jump_enable_out, jump_address_out, busy_out
  );

  modport slave (
    output inst_in, inst_address_in, irq_in,
    output csr_mstatus_in, csr_mtvec_in, csr_mepc_in,
    output pipe_csr_we_in, pipe_csr_waddr_in, pipe_csr_wdata_in,
    input  csr_we_out, csr_waddr_out, csr_wdata_out,
    input  hold_out, jump_enable_out, jump_address_out, busy_out
  );

endinterface

// File: rtl/csr_trap_ctrl_decode.sv
// Combinational classifier for the instruction in exe. is_valid marks an
// ordinary instruction that a timer interrupt is allowed to squash: not a
// system instruction handled here, not a NOP bubble and not an all-zero slot.
module csr_trap_decode
  import csr_trap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] inst,
  output logic                  is_ecall,
  output logic                  is_ebreak,
  output logic                  is_mret,
  output logic                  is_valid
);

  logic is_nop;
  logic is_zero;

  assign is_ecall  = (inst == DATA_WIDTH'(INST_ECALL));
  assign is_ebreak = (inst == DATA_WIDTH'(INST_EBREAK));
  assign is_mret   = (inst == DATA_WIDTH'(INST_MRET));
  assign is_nop    = (inst == DATA_WIDTH'(INST_NOP));
  assign is_zero   = (inst == '0);
  assign is_valid  = ~(is_ecall | is_ebreak | is_mret | is_nop | is_zero);

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer. Takes ECALL/EBREAK/MRET from exe and the timer
// interrupt, writes mepc/mstatus/mcause through the shared CSR write port
// (mem-stage writes always win) and then redirects fetch.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic            clk_in,
  input  logic            reset_in,
  csr_trap_ctrl_if.master bus
);

  logic                      is_ecall;
  logic                      is_ebreak;
  logic                      is_mret;
  logic                      is_valid;
  logic                      take_irq;
  logic                      start_trap;
  trap_state_e               state_q;
  trap_state_e               state_d;
  logic [ADDR_WIDTH-1:0]     pc_q;
  logic [ADDR_WIDTH-1:0]     pc_d;
  logic [DATA_WIDTH-1:0]     cause_q;
  logic [DATA_WIDTH-1:0]     cause_d;
  logic [DATA_WIDTH-1:0]     mstatus_upd;
  logic                      trap_we;
  logic [CSR_ADDR_WIDTH-1:0] trap_waddr;
  logic [DATA_WIDTH-1:0]     trap_wdata;
  logic                      hold;
  logic                      jump_en;
  logic [ADDR_WIDTH-1:0]     jump_addr;
  logic                      pipe_we;

  csr_trap_decode #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_decode (
    .inst     (bus.inst_in),
    .is_ecall (is_ecall),
    .is_ebreak(is_ebreak),
    .is_mret  (is_mret),
    .is_valid (is_valid)
  );

  // System instructions are excluded by is_valid, so they always beat the interrupt.
  assign take_irq   = bus.irq_in & bus.csr_mstatus_in[MIE_BIT] & is_valid;
  assign start_trap = is_ecall | is_ebreak | take_irq;
  assign pipe_we    = bus.pipe_csr_we_in;

  // State, trapping PC and cause registers.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  // Next state plus the sequencer's own CSR write; a write state only advances when the port is free.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    mstatus_upd = bus.csr_mstatus_in;
    trap_we     = 1'b0;
    trap_waddr  = '0;
    trap_wdata  = '0;
    hold        = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = '0;
    case (state_q)
      ST_IDLE: begin
        if (is_mret) begin
          hold    = 1'b1;
          pc_d    = bus.inst_address_in;
          state_d = ST_R_MSTATUS;
        end else if (start_trap) begin
          hold    = 1'b1;
          pc_d    = bus.inst_address_in;
          cause_d = is_ecall  ? DATA_WIDTH'(CAUSE_ECALL)  :
                    is_ebreak ? DATA_WIDTH'(CAUSE_EBREAK) :
                                DATA_WIDTH'(CAUSE_TIMER_IRQ);
          state_d = ST_T_MEPC;
        end
      end
      ST_T_MEPC: begin
        hold       = 1'b1;
        trap_we    = 1'b1;
        trap_waddr = CSR_ADDR_WIDTH'(CSR_MEPC);
        trap_wdata = DATA_WIDTH'(pc_q);
        if (!pipe_we) state_d = ST_T_MSTATUS;
      end
      ST_T_MSTATUS: begin
        hold                  = 1'b1;
        mstatus_upd[MPIE_BIT] = bus.csr_mstatus_in[MIE_BIT];
        mstatus_upd[MIE_BIT]  = 1'b0;
        trap_we               = 1'b1;
        trap_waddr            = CSR_ADDR_WIDTH'(CSR_MSTATUS);
        trap_wdata            = mstatus_upd;
        if (!pipe_we) state_d = ST_T_MCAUSE;
      end
      ST_T_MCAUSE: begin
        hold       = 1'b1;
        trap_we    = 1'b1;
        trap_waddr = CSR_ADDR_WIDTH'(CSR_MCAUSE);
        trap_wdata = cause_q;
        if (!pipe_we) state_d = ST_T_JUMP;
      end
      ST_T_JUMP: begin
        jump_en   = 1'b1;
        jump_addr = ADDR_WIDTH'(bus.csr_mtvec_in & ~DATA_WIDTH'(3));
        state_d   = ST_IDLE;
      end
      ST_R_MSTATUS: begin
        hold                  = 1'b1;
        mstatus_upd[MIE_BIT]  = bus.csr_mstatus_in[MPIE_BIT];
        mstatus_upd[MPIE_BIT] = 1'b1;
        trap_we               = 1'b1;
        trap_waddr            = CSR_ADDR_WIDTH'(CSR_MSTATUS);
        trap_wdata            = mstatus_upd;
        if (!pipe_we) state_d = ST_R_JUMP;
      end
      ST_R_JUMP: begin
        jump_en   = 1'b1;
        jump_addr = ADDR_WIDTH'(bus.csr_mepc_in);
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write-port arbitration and output gating: everything reads zero while reset is held.
  assign bus.csr_we_out       = reset_in & (pipe_we | trap_we);
  assign bus.csr_waddr_out    = !reset_in ? '0 : (pipe_we ? bus.pipe_csr_waddr_in : trap_waddr);
  assign bus.csr_wdata_out    = !reset_in ? '0 : (pipe_we ? bus.pipe_csr_wdata_in : trap_wdata);
  assign bus.hold_out         = reset_in & hold;
  assign bus.jump_enable_out  = reset_in & jump_en;
  assign bus.jump_address_out = reset_in ? jump_addr : '0;
  assign bus.busy_out         = reset_in & (state_q != ST_IDLE);

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Testbench for csr_trap_ctrl: directed cycle tables, a reset-in-sequence
// case and random traffic checked against a plan-queue reference model.
module tb_csr_trap_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADD    = 32'h00c5_8533;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        irq;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        pipe_we;
    logic [11:0] pipe_addr;
    logic [31:0] pipe_data;
  } stim_t;

  typedef struct {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        hold;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        busy;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t r;
  } vec_t;

  typedef enum {K_MEPC, K_MST_T, K_MCAUSE, K_JMP_T, K_MST_R, K_JMP_R} kind_e;

  typedef struct {
    kind_e       k;
    logic [31:0] v;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;
  int   error_count = 0;
  int   check_count = 0;
  vec_t vecs[$];
  step_t plan[$];

  always #5 clk = ~clk;

  csr_trap_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) bus ();

  csr_trap_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .CSR_ADDR_WIDTH(12)
  ) dut (
    .clk_in  (clk),
    .reset_in(rst_n),
    .bus     (bus)
  );

  function automatic stim_t st(input logic [31:0] inst, input logic [31:0] pc, input logic irq,
                               input logic [31:0] mst, input logic [31:0] mtvec, input logic [31:0] mepc,
                               input logic pwe, input logic [11:0] paddr, input logic [31:0] pdata);
    stim_t s;
    s.inst = inst; s.pc = pc; s.irq = irq; s.mstatus = mst; s.mtvec = mtvec; s.mepc = mepc;
    s.pipe_we = pwe; s.pipe_addr = paddr; s.pipe_data = pdata;
    return s;
  endfunction

  function automatic resp_t rs(input logic we, input logic [11:0] waddr, input logic [31:0] wdata,
                               input logic hold, input logic jmp, input logic [31:0] jaddr, input logic busy);
    resp_t r;
    r.we = we; r.waddr = waddr; r.wdata = wdata; r.hold = hold;
    r.jump_en = jmp; r.jump_addr = jaddr; r.busy = busy;
    return r;
  endfunction

  function automatic step_t mk_step(input kind_e k, input logic [31:0] v);
    step_t p;
    p.k = k;
    p.v = v;
    return p;
  endfunction

  task automatic add_vec(input stim_t s, input resp_t r);
    vec_t v;
    v.s = s;
    v.r = r;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input stim_t s);
    bus.inst_in           = s.inst;
    bus.inst_address_in   = s.pc;
    bus.irq_in            = s.irq;
    bus.csr_mstatus_in    = s.mstatus;
    bus.csr_mtvec_in      = s.mtvec;
    bus.csr_mepc_in       = s.mepc;
    bus.pipe_csr_we_in    = s.pipe_we;
    bus.pipe_csr_waddr_in = s.pipe_addr;
    bus.pipe_csr_wdata_in = s.pipe_data;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input resp_t e);
    chk({tag, " csr_we"},    32'(bus.csr_we_out),      32'(e.we));
    chk({tag, " csr_waddr"}, 32'(bus.csr_waddr_out),   32'(e.waddr));
    chk({tag, " csr_wdata"}, bus.csr_wdata_out,        e.wdata);
    chk({tag, " hold"},      32'(bus.hold_out),        32'(e.hold));
    chk({tag, " jump_en"},   32'(bus.jump_enable_out), 32'(e.jump_en));
    chk({tag, " jump_addr"}, bus.jump_address_out,     e.jump_addr);
    chk({tag, " busy"},      32'(bus.busy_out),        32'(e.busy));
  endtask

  // Reference model: an idle controller turns a trap/MRET into a plan of steps;
  // a write step is only consumed when the mem stage leaves the port free.
  task automatic model_eval(input stim_t s, output resp_t e);
    step_t       head;
    logic [31:0] cause;
    logic [31:0] m;
    bit          trap;
    e = rs(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    if (s.pipe_we) begin
      e.we = 1'b1; e.waddr = s.pipe_addr; e.wdata = s.pipe_data;
    end
    if (plan.size() == 0) begin
      trap  = 1'b0;
      cause = 32'h0;
      if (s.inst == ECALL) begin
        trap = 1'b1; cause = 32'd11;
      end else if (s.inst == EBREAK) begin
        trap = 1'b1; cause = 32'd3;
      end else if (s.inst == MRET) begin
        e.hold = 1'b1;
        plan.push_back(mk_step(K_MST_R, 32'h0));
        plan.push_back(mk_step(K_JMP_R, 32'h0));
      end else if (s.irq && s.mstatus[3] && s.inst != NOP && s.inst != 32'h0) begin
        trap = 1'b1; cause = 32'h8000_0007;
      end
      if (trap) begin
        e.hold = 1'b1;
        plan.push_back(mk_step(K_MEPC, s.pc));
        plan.push_back(mk_step(K_MST_T, 32'h0));
        plan.push_back(mk_step(K_MCAUSE, cause));
        plan.push_back(mk_step(K_JMP_T, 32'h0));
      end
    end else begin
      e.busy = 1'b1;
      head = plan[0];
      if (head.k == K_JMP_T) begin
        e.jump_en = 1'b1; e.jump_addr = {s.mtvec[31:2], 2'b00};
        void'(plan.pop_front());
      end else if (head.k == K_JMP_R) begin
        e.jump_en = 1'b1; e.jump_addr = s.mepc;
        void'(plan.pop_front());
      end else begin
        e.hold = 1'b1;
        if (!s.pipe_we) begin
          e.we = 1'b1;
          m = s.mstatus;
          case (head.k)
            K_MEPC:   begin e.waddr = 12'h341; e.wdata = head.v; end
            K_MCAUSE: begin e.waddr = 12'h342; e.wdata = head.v; end
            K_MST_T:  begin m[7] = s.mstatus[3]; m[3] = 1'b0; e.waddr = 12'h300; e.wdata = m; end
            default:  begin m[3] = s.mstatus[7]; m[7] = 1'b1; e.waddr = 12'h300; e.wdata = m; end
          endcase
          void'(plan.pop_front());
        end
      end
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    case ($urandom_range(0, 9))
      0:       s.inst = ECALL;
      1:       s.inst = EBREAK;
      2:       s.inst = MRET;
      3:       s.inst = NOP;
      4:       s.inst = 32'h0;
      default: s.inst = $urandom;
    endcase
    s.pc        = $urandom & 32'hffff_fffc;
    s.irq       = 1'($urandom_range(0, 1));
    s.mstatus   = $urandom;
    s.mtvec     = $urandom;
    s.mepc      = $urandom;
    s.pipe_we   = ($urandom_range(0, 3) == 0);
    s.pipe_addr = 12'($urandom);
    s.pipe_data = $urandom;
    return s;
  endfunction

  initial begin
    stim_t  idle_s;
    stim_t  s;
    resp_t  e;
    resp_t  zero_r;

    zero_r = rs(0, 12'h0, 32'h0, 0, 0, 32'h0, 0);
    idle_s = st(NOP, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 12'h0, 32'h0);

    // ECALL, MIE=1: mepc, mstatus, mcause, then jump on the 4th cycle
    add_vec(st(ECALL, 32'h100, 0, 32'h8,  32'h200, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,   1, 0, 32'h0,   0));
    add_vec(st(NOP,   32'h104, 0, 32'h8,  32'h200, 0, 0, 0, 0), rs(1, 12'h341, 32'h100, 1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h104, 0, 32'h8,  32'h200, 0, 0, 0, 0), rs(1, 12'h300, 32'h80,  1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h104, 0, 32'h80, 32'h200, 0, 0, 0, 0), rs(1, 12'h342, 32'd11,  1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h104, 0, 32'h80, 32'h200, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,   0, 1, 32'h200, 1));
    add_vec(st(NOP,   32'h200, 0, 32'h80, 32'h200, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,   0, 0, 32'h0,   0));
    // Timer interrupt on ADD with MIE=1, then MIE=0 and non-interruptible slots
    add_vec(st(ADD, 32'h40,  1, 32'h8,  32'h200, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,         1, 0, 32'h0,   0));
    add_vec(st(ADD, 32'h40,  1, 32'h8,  32'h200, 0, 0, 0, 0), rs(1, 12'h341, 32'h40,        1, 0, 32'h0,   1));
    add_vec(st(ADD, 32'h40,  1, 32'h8,  32'h200, 0, 0, 0, 0), rs(1, 12'h300, 32'h80,        1, 0, 32'h0,   1));
    add_vec(st(ADD, 32'h40,  1, 32'h80, 32'h200, 0, 0, 0, 0), rs(1, 12'h342, 32'h8000_0007, 1, 0, 32'h0,   1));
    add_vec(st(ADD, 32'h40,  1, 32'h80, 32'h200, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,         0, 1, 32'h200, 1));
    add_vec(st(ADD, 32'h200, 1, 32'h80, 32'h200, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,         0, 0, 32'h0,   0));
    add_vec(st(ADD, 32'h204, 1, 32'h0,  32'h200, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,         0, 0, 32'h0,   0));
    add_vec(st(NOP, 32'h208, 1, 32'h8,  32'h200, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,         0, 0, 32'h0,   0));
    add_vec(st(0,   32'h20c, 1, 32'h8,  32'h200, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,         0, 0, 32'h0,   0));
    // MRET: mstatus 0x80 -> 0x88, jump to mepc two cycles after detect
    add_vec(st(MRET, 32'h300, 0, 32'h80, 32'h200, 32'h44, 0, 0, 0), rs(0, 12'h0,   32'h0,  1, 0, 32'h0,  0));
    add_vec(st(NOP,  32'h304, 0, 32'h80, 32'h200, 32'h44, 0, 0, 0), rs(1, 12'h300, 32'h88, 1, 0, 32'h0,  1));
    add_vec(st(NOP,  32'h304, 0, 32'h88, 32'h200, 32'h44, 0, 0, 0), rs(0, 12'h0,   32'h0,  0, 1, 32'h44, 1));
    add_vec(st(NOP,  32'h44,  0, 32'h88, 32'h200, 32'h44, 0, 0, 0), rs(0, 12'h0,   32'h0,  0, 0, 32'h0,  0));
    // EBREAK beats a pending irq, other mstatus bits kept, mtvec low bits dropped
    add_vec(st(EBREAK, 32'h80,  1, 32'h1808, 32'h203, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,    1, 0, 32'h0,   0));
    add_vec(st(NOP,    32'h84,  1, 32'h1808, 32'h203, 0, 0, 0, 0), rs(1, 12'h341, 32'h80,   1, 0, 32'h0,   1));
    add_vec(st(NOP,    32'h84,  1, 32'h1808, 32'h203, 0, 0, 0, 0), rs(1, 12'h300, 32'h1880, 1, 0, 32'h0,   1));
    add_vec(st(NOP,    32'h84,  1, 32'h1880, 32'h203, 0, 0, 0, 0), rs(1, 12'h342, 32'd3,    1, 0, 32'h0,   1));
    add_vec(st(NOP,    32'h84,  1, 32'h1880, 32'h203, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,    0, 1, 32'h200, 1));
    add_vec(st(NOP,    32'h200, 0, 32'h1880, 32'h203, 0, 0, 0, 0), rs(0, 12'h0,   32'h0,    0, 0, 32'h0,   0));
    // Idle pipe write passes straight through
    add_vec(st(NOP, 32'h10, 0, 32'h0, 32'h200, 0, 1, 12'h123, 32'hdead_beef), rs(1, 12'h123, 32'hdead_beef, 0, 0, 32'h0, 0));
    // Two pipe writes during T_MEPC stall the sequence by two cycles
    add_vec(st(ECALL, 32'h100, 0, 32'h8,  32'h200, 0, 0, 12'h0,   32'h0),    rs(0, 12'h0,   32'h0,    1, 0, 32'h0,   0));
    add_vec(st(NOP,   32'h104, 0, 32'h8,  32'h200, 0, 1, 12'h340, 32'haaaa), rs(1, 12'h340, 32'haaaa,  1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h104, 0, 32'h8,  32'h200, 0, 1, 12'h340, 32'hbbbb), rs(1, 12'h340, 32'hbbbb,  1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h104, 0, 32'h8,  32'h200, 0, 0, 12'h0,   32'h0),    rs(1, 12'h341, 32'h100,   1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h104, 0, 32'h8,  32'h200, 0, 0, 12'h0,   32'h0),    rs(1, 12'h300, 32'h80,    1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h104, 0, 32'h80, 32'h200, 0, 0, 12'h0,   32'h0),    rs(1, 12'h342, 32'd11,    1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h104, 0, 32'h80, 32'h200, 0, 0, 12'h0,   32'h0),    rs(0, 12'h0,   32'h0,     0, 1, 32'h200, 1));
    add_vec(st(NOP,   32'h200, 0, 32'h80, 32'h200, 0, 0, 12'h0,   32'h0),    rs(0, 12'h0,   32'h0,     0, 0, 32'h0,   0));
    // Pipe mstatus write lands first; trap value is computed from the new mstatus
    add_vec(st(ECALL, 32'h500, 0, 32'h0,  32'h600, 0, 0, 12'h0,   32'h0), rs(0, 12'h0,   32'h0,   1, 0, 32'h0,   0));
    add_vec(st(NOP,   32'h504, 0, 32'h0,  32'h600, 0, 0, 12'h0,   32'h0), rs(1, 12'h341, 32'h500, 1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h504, 0, 32'h0,  32'h600, 0, 1, 12'h300, 32'h8), rs(1, 12'h300, 32'h8,   1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h504, 0, 32'h8,  32'h600, 0, 0, 12'h0,   32'h0), rs(1, 12'h300, 32'h80,  1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h504, 0, 32'h80, 32'h600, 0, 0, 12'h0,   32'h0), rs(1, 12'h342, 32'd11,  1, 0, 32'h0,   1));
    add_vec(st(NOP,   32'h504, 0, 32'h80, 32'h600, 0, 0, 12'h0,   32'h0), rs(0, 12'h0,   32'h0,   0, 1, 32'h600, 1));
    add_vec(st(NOP,   32'h600, 0, 32'h80, 32'h600, 0, 0, 12'h0,   32'h0), rs(0, 12'h0,   32'h0,   0, 0, 32'h0,   0));

    rst_n = 1'b0;
    applyStimulus(idle_s);
    #12;
    checkOutput("reset", zero_r);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i].s);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].r);
    end

    // Reset asserted while in T_MCAUSE: outputs drop at once, no jump afterwards
    @(posedge clk);
    #1;
    applyStimulus(st(ECALL, 32'h700, 0, 32'h8, 32'h200, 0, 0, 12'h0, 32'h0));
    @(negedge clk);
    checkOutput("rst_seq detect", rs(0, 12'h0, 32'h0, 1, 0, 32'h0, 0));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      applyStimulus(st(NOP, 32'h704, 0, (c == 0) ? 32'h8 : 32'h80, 32'h200, 0, 0, 12'h0, 32'h0));
    end
    @(negedge clk);
    checkOutput("rst_seq mcause", rs(1, 12'h342, 32'd11, 1, 0, 32'h0, 1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_seq asserted", zero_r);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_seq held", zero_r);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      applyStimulus(st(NOP, 32'h800, 0, 32'h80, 32'h200, 0, 0, 12'h0, 32'h0));
      @(negedge clk);
      checkOutput($sformatf("rst_seq after%0d", c), zero_r);
    end

    // Random traffic against the plan-queue model
    plan.delete();
    for (int n = 0; n < 400; n++) begin
      s = rand_stim();
      @(posedge clk);
      #1;
      applyStimulus(s);
      model_eval(s, e);
      @(negedge clk);
      checkOutput($sformatf("rand%0d", n), e);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
